bin2csd_seq_ctrl: RTL and testbench

BIN2CSD_SEQ_CTRL -- requirements
Module: bin2csd_seq_ctrl

---
 rtl/bin2csd_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_bin2csd_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2csd_seq_ctrl.sv
// Serial binary-to-CSD converter: accepts a W-bit two's-complement operand and
// emits one canonical-signed-digit per cycle (LSB first), then holds the packed result.
module bin2csd_seq_ctrl #(
  parameter int W  = 5,
  parameter int CW = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic             flush,
  output logic             dig_valid,
  output logic [1:0]       dig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   y,
  output logic [CW-1:0]    nz_cnt,
  output logic             busy
);

  localparam int            IW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [W-1:0]     operand_r;
  logic             carry_r;
  logic [IW-1:0]    idx_r;
  logic [2*W-1:0]   y_r;
  logic [CW-1:0]    nz_r;
  logic [W:0]       ext_s;
  logic [2:0]       step_s;
  logic [1:0]       dig_s;
  logic             carry_next_s;
  logic             accept_s;

  // One recurrence step: returns {carry_out, digit}. A nonzero digit only arises
  // when x_i + c_i is odd; its sign is set by whether the next bit produces a carry.
  function automatic logic [2:0] csd_step(input logic xi, input logic xn, input logic ci);
    logic [1:0] sum;
    logic       cn;
    logic [1:0] d;
    sum = {1'b0, xi} + {1'b0, ci} + {1'b0, xn};
    cn  = sum[1];
    if (xi ^ ci) begin
      d = cn ? 2'b11 : 2'b01;
    end else begin
      d = 2'b00;
    end
    return {cn, d};
  endfunction

  // Digit datapath: sign-extended operand shifted so bits 0/1 are x_i and x_{i+1}
  always_comb begin
    ext_s        = {operand_r[W-1], operand_r} >> idx_r;
    step_s       = csd_step(ext_s[0], ext_s[1], carry_r);
    carry_next_s = step_s[2];
    dig_s        = step_s[1:0];
    accept_s     = (state_r == IDLE) && in_valid && !flush;
  end

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = in_valid ? RUN : IDLE;
        RUN:     state_s = (idx_r == LAST_IDX) ? DONE : RUN;
        DONE:    state_s = out_ready ? IDLE : DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Output decode from state
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    dig_valid = 1'b0;
    out_valid = 1'b0;
    dig       = 2'b00;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      RUN: begin
        dig_valid = 1'b1;
        dig       = dig_s;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Operand, carry, index and result accumulation
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      operand_r <= {W{1'b0}};
      carry_r   <= 1'b0;
      idx_r     <= {IW{1'b0}};
      y_r       <= {(2*W){1'b0}};
      nz_r      <= {CW{1'b0}};
    end else if (flush) begin
      carry_r <= 1'b0;
      idx_r   <= {IW{1'b0}};
      y_r     <= {(2*W){1'b0}};
      nz_r    <= {CW{1'b0}};
    end else if (accept_s) begin
      operand_r <= x;
      carry_r   <= 1'b0;
      idx_r     <= {IW{1'b0}};
      y_r       <= {(2*W){1'b0}};
      nz_r      <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      // y is cleared on accept, so OR-ing the shifted digit writes slot idx_r
      y_r     <= y_r | ({{(2*W-2){1'b0}}, dig_s} << {idx_r, 1'b0});
      carry_r <= carry_next_s;
      idx_r   <= (idx_r == LAST_IDX) ? {IW{1'b0}} : idx_r + IW'(1);
      if (dig_s != 2'b00) begin
        nz_r <= nz_r + CW'(1);
      end
    end
  end

  assign y      = y_r;
  assign nz_cnt = nz_r;

endmodule

// File: tb/tb_bin2csd_seq_ctrl.sv
// Self-checking bench for bin2csd_seq_ctrl: table vectors, corner sequences and an
// exhaustive sweep, with a scoreboard fed by an independent NAF reference model.
module tb_bin2csd_seq_ctrl;
  localparam int W  = 5;
  localparam int CW = 3;

  typedef struct {
    logic [W-1:0]   x;
    logic [2*W-1:0] y;
    logic [CW-1:0]  nz;
  } vec_t;

  logic           clk = 1'b0;
  logic           arst_n, in_valid, in_ready, flush, dig_valid, out_valid, out_ready, busy;
  logic [W-1:0]   x;
  logic [1:0]     dig;
  logic [2*W-1:0] y;
  logic [CW-1:0]  nz_cnt;

  int   checks = 0;
  int   errors = 0;
  vec_t res_q[$];
  logic [1:0] dig_q[$];
  vec_t tbl[5];

  bin2csd_seq_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .flush(flush), .dig_valid(dig_valid), .dig(dig), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .nz_cnt(nz_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: non-adjacent form by repeated halving of the signed value
  function automatic void naf(input logic [W-1:0] xv, output logic [2*W-1:0] yv, output int nz);
    int v;
    int m;
    v  = int'($signed(xv));
    yv = '0;
    nz = 0;
    for (int i = 0; i < W; i++) begin
      m = ((v % 4) + 4) % 4;
      if (m == 1) begin
        yv[2*i +: 2] = 2'b01; v = v - 1; nz++;
      end else if (m == 3) begin
        yv[2*i +: 2] = 2'b11; v = v + 1; nz++;
      end
      v = v / 2;
    end
  endfunction

  function automatic int y_value(input logic [2*W-1:0] yv);
    int s = 0;
    for (int i = 0; i < W; i++) begin
      if (yv[2*i +: 2] == 2'b01) s += (1 << i);
      else if (yv[2*i +: 2] == 2'b11) s -= (1 << i);
    end
    return s;
  endfunction

  function automatic int has_adj(input logic [2*W-1:0] yv);
    int a = 0;
    for (int i = 0; i < W - 1; i++)
      if (yv[2*i +: 2] != 2'b00 && yv[2*i+2 +: 2] != 2'b00) a = 1;
    return a;
  endfunction

  function automatic int count_nz(input logic [2*W-1:0] yv);
    int n = 0;
    for (int i = 0; i < W; i++) if (yv[2*i +: 2] != 2'b00) n++;
    return n;
  endfunction

  task automatic push_expect(input logic [W-1:0] xv);
    logic [2*W-1:0] yv;
    int nz;
    vec_t e;
    naf(xv, yv, nz);
    e.x = xv; e.y = yv; e.nz = CW'(nz);
    res_q.push_back(e);
    for (int i = 0; i < W; i++) dig_q.push_back(yv[2*i +: 2]);
  endtask

  task automatic monitor();
    vec_t e;
    forever begin
      @(negedge clk);
      if (dig_valid) begin
        check("dig_not_10", 32'(dig == 2'b10), 32'd0);
        if (dig_q.size() == 0) fail("dig_unexpected");
        else check("dig", 32'(dig), 32'(dig_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (res_q.size() == 0) fail("result_unexpected");
        else begin
          e = res_q.pop_front();
          check("y", 32'(y), 32'(e.y));
          check("nz_cnt", 32'(nz_cnt), 32'(e.nz));
          check("value", 32'(y_value(y)), 32'(int'($signed(e.x))));
          check("adjacent", 32'(has_adj(y)), 32'd0);
          check("nz_vs_y", 32'(count_nz(y)), 32'(nz_cnt));
        end
      end
    end
  endtask

  task automatic start(input logic [W-1:0] xv);
    push_expect(xv);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x = xv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = W'($urandom);
  endtask

  task automatic convert(input logic [W-1:0] xv, input bit rnd, output int lat,
                         output logic [2*W-1:0] ycap, output logic [CW-1:0] nzcap);
    bit fire;
    bit done = 1'b0;
    lat = 0; ycap = '0; nzcap = '0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start(xv);
    for (int c = 1; c <= 60 && !done; c++) begin
      if (out_valid && lat == 0) begin
        lat = c; ycap = y; nzcap = nz_cnt;
      end
      fire = out_valid && out_ready;
      @(posedge clk); #1;
      if (fire) done = 1'b1;
      else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    out_ready = 1'b0;
    if (!done) fail("handshake_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dig_valid"}, 32'(dig_valid), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_dig"}, 32'(dig), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_nz"}, 32'(nz_cnt), 32'd0);
  endtask

  initial begin
    int lat;
    logic [2*W-1:0] yc, y0;
    logic [CW-1:0] nc, n0;
    bit seen;

    tbl[0] = '{5'b01011, 10'b0100110011, 3'd3};
    tbl[1] = '{5'b10000, 10'b1100000000, 3'd1};
    tbl[2] = '{5'b11111, 10'b0000000011, 3'd1};
    tbl[3] = '{5'b00000, 10'b0000000000, 3'd0};
    tbl[4] = '{5'b01010, 10'b0001000100, 3'd2};

    arst_n = 1'b0; in_valid = 1'b0; x = '0; flush = 1'b0; out_ready = 1'b0;
    fork monitor(); join_none
    #2;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    arst_n = 1'b1;

    // Table vectors with a ready consumer
    for (int i = 0; i < 5; i++) begin
      convert(tbl[i].x, 1'b0, lat, yc, nc);
      check("tbl_y", 32'(yc), 32'(tbl[i].y));
      check("tbl_nz", 32'(nc), 32'(tbl[i].nz));
      check("tbl_latency", 32'(lat), 32'(W + 1));
    end

    // Consumer stall in DONE with a competing in_valid
    out_ready = 1'b0;
    start(5'b01011);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) fail("stall_done_timeout");
    y0 = y; n0 = nz_cnt;
    check("stall_y", 32'(y0), 32'(10'b0100110011));
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; x = W'($urandom);
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_y_hold", 32'(y), 32'(y0));
      check("stall_nz_hold", 32'(nz_cnt), 32'(n0));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release_busy", 32'(busy), 32'd0);
    check("stall_release_out_valid", 32'(out_valid), 32'd0);

    // Flush in the third RUN cycle
    start(5'b00111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("flush_pre_dig_valid", 32'(dig_valid), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    dig_q.delete(); res_q.delete();
    check_reset_outputs("flush");
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("flush_no_result", 32'(out_valid), 32'd0);
    end
    convert(5'b01010, 1'b0, lat, yc, nc);
    check("after_flush_y", 32'(yc), 32'(10'b0001000100));

    // Asynchronous reset pulse during RUN
    start(5'b01011);
    @(posedge clk); #1;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    dig_q.delete(); res_q.delete();
    @(posedge clk); #1;
    arst_n = 1'b1;
    convert(5'b01011, 1'b0, lat, yc, nc);
    check("after_arst_y", 32'(yc), 32'(10'b0100110011));
    check("after_arst_nz", 32'(nc), 32'd3);

    // Exhaustive sweep with a random consumer
    for (int v = 0; v < 32; v++) convert(W'(v), 1'b1, lat, yc, nc);

    repeat (3) @(posedge clk);
    if (res_q.size() != 0 || dig_q.size() != 0) fail("scoreboard_leftover");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
